// File: rtl/serv_immenc_if.sv
// Result channel of the serial immediate encoder: finished instruction word
// plus its flags, transferred on a valid/ready handshake.
interface serv_immenc_if;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_insn;
  logic        o_ovf;
  logic        o_misalign;

  modport master (output o_valid, output o_insn, output o_ovf, output o_misalign, input i_ready);
  modport slave  (input o_valid, input o_insn, input o_ovf, input o_misalign, output i_ready);
endinterface

// File: rtl/serv_immenc.sv
// Bit-serial RISC-V immediate encoder: scatters an LSB-first immediate into the
// I/S/B/U/J field layout of a template instruction and offers the result.
module serv_immenc #(
  parameter bit SIGN_CHECK = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [2:0]           i_fmt,
  input  logic [31:0]          i_tmpl,
  input  logic                 i_cnt_en,
  input  logic                 i_bit,
  output logic                 o_busy,
  serv_immenc_if.master        bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  typedef struct packed {
    logic       hit;
    logic [4:0] pos;
  } map_t;

  // Instruction position of immediate bit k for a given format; hit=0 means discarded.
  function automatic map_t map_bit(input logic [2:0] fmt, input logic [4:0] k);
    map_t m;
    m.hit = 1'b0;
    m.pos = 5'd0;
    case (fmt)
      FMT_I: if (k <= 5'd11) begin m.hit = 1'b1; m.pos = k + 5'd20; end
      FMT_S: begin
        if (k >= 5'd5 && k <= 5'd11) begin m.hit = 1'b1; m.pos = k + 5'd20; end
        else if (k <= 5'd4)          begin m.hit = 1'b1; m.pos = k + 5'd7;  end
      end
      FMT_B: begin
        if (k == 5'd12)                    begin m.hit = 1'b1; m.pos = 5'd31;      end
        else if (k >= 5'd5 && k <= 5'd10)  begin m.hit = 1'b1; m.pos = k + 5'd20;  end
        else if (k >= 5'd1 && k <= 5'd4)   begin m.hit = 1'b1; m.pos = k + 5'd7;   end
        else if (k == 5'd11)               begin m.hit = 1'b1; m.pos = 5'd7;       end
      end
      FMT_U: if (k >= 5'd12) begin m.hit = 1'b1; m.pos = k; end
      FMT_J: begin
        if (k == 5'd20)                    begin m.hit = 1'b1; m.pos = 5'd31;      end
        else if (k >= 5'd1 && k <= 5'd10)  begin m.hit = 1'b1; m.pos = k + 5'd20;  end
        else if (k == 5'd11)               begin m.hit = 1'b1; m.pos = 5'd20;      end
        else if (k >= 5'd12 && k <= 5'd19) begin m.hit = 1'b1; m.pos = k;          end
      end
      default: ;
    endcase
    return m;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_word;
  logic [2:0]  r_fmt;
  logic        r_sign;
  logic        r_ovf;
  logic        r_misalign;

  map_t        w_map;
  logic        w_signed;
  logic [4:0]  w_sidx;
  logic        w_addr_fmt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_signed   = 1'b0;
    w_sidx     = 5'd11;
    w_addr_fmt = 1'b0;
    w_map      = map_bit(r_fmt, r_cnt);
    case (r_fmt)
      FMT_I, FMT_S: w_signed = 1'b1;
      FMT_B: begin w_signed = 1'b1; w_sidx = 5'd12; w_addr_fmt = 1'b1; end
      FMT_J: begin w_signed = 1'b1; w_sidx = 5'd20; w_addr_fmt = 1'b1; end
      default: ;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state    <= ST_IDLE;
      r_cnt      <= 5'd0;
      r_word     <= 32'd0;
      r_fmt      <= 3'd0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_word     <= i_tmpl;
          r_fmt      <= i_fmt;
          r_cnt      <= 5'd0;
          r_sign     <= 1'b0;
          r_ovf      <= 1'b0;
          r_misalign <= 1'b0;
        end
        ST_SHIFT: if (i_cnt_en) begin
          r_cnt <= r_cnt + 5'd1;
          if (w_map.hit) r_word[w_map.pos] <= i_bit;
          if (w_addr_fmt && r_cnt == 5'd0) r_misalign <= i_bit;
          if (SIGN_CHECK) begin
            if (w_signed && r_cnt == w_sidx) r_sign <= i_bit;
            // Sign bit is latched before any higher bit arrives, so the compare is valid.
            if (w_signed && r_cnt > w_sidx && i_bit != r_sign) r_ovf <= 1'b1;
            if (r_fmt == FMT_U && r_cnt < 5'd12 && i_bit) r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_SHIFT;
      ST_SHIFT: if (i_cnt_en && r_cnt == 5'd31) w_next = ST_DONE;
      ST_DONE:  if (bus.i_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_busy         = (r_state == ST_SHIFT);
    bus.o_valid    = (r_state == ST_DONE);
    bus.o_insn     = r_word;
    bus.o_ovf      = r_ovf;
    bus.o_misalign = r_misalign;
  end

endmodule

// File: tb/tb_serv_immenc.sv
// Directed bench for serv_immenc: expected words are queued at stimulus time
// and popped when the encoder presents a result.
module tb_serv_immenc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  fmt;
  logic [31:0] tmpl;
  logic        cnt_en;
  logic        bit_in;
  logic        busy;

  serv_immenc_if bus ();

  serv_immenc #(.SIGN_CHECK(1'b1)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_fmt    (fmt),
    .i_tmpl   (tmpl),
    .i_cnt_en (cnt_en),
    .i_bit    (bit_in),
    .o_busy   (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] insn;
    logic        ovf;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference layout, written as whole-word concatenations.
  function automatic logic [31:0] model_insn(input logic [2:0] f, input logic [31:0] t, input logic [31:0] m);
    case (f)
      3'd0: return {m[11:0], t[19:0]};
      3'd1: return {m[11:5], t[24:12], m[4:0], t[6:0]};
      3'd2: return {m[12], m[10:5], t[24:12], m[4:1], m[11], t[6:0]};
      3'd3: return {m[31:12], t[11:0]};
      3'd4: return {m[20], m[10:1], m[11], m[19:12], t[11:0]};
      default: return t;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [2:0] f, input logic [31:0] m);
    case (f)
      3'd0, 3'd1: return !((&m[31:11]) || !(|m[31:11]));
      3'd2:       return !((&m[31:12]) || !(|m[31:12]));
      3'd3:       return |m[11:0];
      3'd4:       return !((&m[31:20]) || !(|m[31:20]));
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] f, input logic [31:0] m);
    return (f == 3'd2 || f == 3'd4) ? m[0] : 1'b0;
  endfunction

  // Start a job and stream nbits of imm; gaps inserts random idle cycles.
  task automatic send(input string tag, input logic [2:0] f, input logic [31:0] t,
                      input logic [31:0] imm, input bit gaps, input int nbits);
    start = 1'b1; fmt = f; tmpl = t;
    tick();
    start = 1'b0; fmt = 3'd0; tmpl = 32'd0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < nbits; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          cnt_en = 1'b0; bit_in = $urandom_range(0, 1);
          tick();
        end
      end
      cnt_en = 1'b1; bit_in = imm[k];
      tick();
    end
    cnt_en = 1'b0; bit_in = 1'b0;
  endtask

  // Wait for a result, hold off i_ready for stall cycles, then accept it.
  task automatic receive(input int stall, input bit poke_start);
    exp_t e;
    int   n = 0;
    while (!bus.o_valid && n < 100) begin tick(); n++; end
    e = sb.pop_front();
    check({e.tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    for (int d = 0; d < stall; d++) begin
      start  = poke_start && (d == 1);
      cnt_en = 1'b1;
      tick();
      start  = 1'b0;
      cnt_en = 1'b0;
      check({e.tag, "_stall_valid"}, {31'd0, bus.o_valid}, 32'd1);
      check({e.tag, "_stall_insn"}, bus.o_insn, e.insn);
    end
    check({e.tag, "_insn"}, bus.o_insn, e.insn);
    check({e.tag, "_ovf"}, {31'd0, bus.o_ovf}, {31'd0, e.ovf});
    check({e.tag, "_mis"}, {31'd0, bus.o_misalign}, {31'd0, e.mis});
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check({e.tag, "_idle_valid"}, {31'd0, bus.o_valid}, 32'd0);
    check({e.tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input string tag, input logic [31:0] insn, input logic ovf, input logic mis);
    exp_t e;
    e.tag = tag; e.insn = insn; e.ovf = ovf; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag, input logic [2:0] f, input logic [31:0] t, input logic [31:0] m);
    push(tag, model_insn(f, t, m), model_ovf(f, m), model_mis(f, m));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fmt = 3'd0; tmpl = 32'd0;
    cnt_en = 1'b0; bit_in = 1'b0; bus.i_ready = 1'b0;
    tick(); tick();
    check("rst_insn",  bus.o_insn, 32'd0);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, bus.o_ovf, bus.o_misalign}, 32'd0);
    rst_n = 1'b1;
    tick();

    // I-format, all ones then a lone bit 11 (overflow).
    push("i_ones", 32'hFFF00013, 1'b0, 1'b0);
    send("i_ones", 3'd0, 32'h00000013, 32'hFFFFFFFF, 1'b0, 32);
    receive(0, 1'b0);
    push("i_ovf", 32'h80000013, 1'b1, 1'b0);
    send("i_ovf", 3'd0, 32'h00000013, 32'h00000800, 1'b0, 32);
    receive(0, 1'b0);

    // S-format.
    push("s_fmt", 32'h7E002FA3, 1'b0, 1'b0);
    send("s_fmt", 3'd1, 32'h00002023, 32'h000007FF, 1'b0, 32);
    receive(0, 1'b0);

    // B-format, aligned then misaligned.
    push("b_neg", 32'hFE000FE3, 1'b0, 1'b0);
    send("b_neg", 3'd2, 32'h00000063, 32'hFFFFFFFE, 1'b0, 32);
    receive(0, 1'b0);
    push("b_mis", 32'h00000163, 1'b0, 1'b1);
    send("b_mis", 3'd2, 32'h00000063, 32'h00000003, 1'b0, 32);
    receive(0, 1'b0);

    // Same B word with random enable gaps, then 5-cycle backpressure with a start poke.
    push("b_gaps", 32'hFE000FE3, 1'b0, 1'b0);
    send("b_gaps", 3'd2, 32'h00000063, 32'hFFFFFFFE, 1'b1, 32);
    receive(5, 1'b1);

    // J and U via the reference layout, a U overflow, and a reserved format.
    push_model("j_fmt", 3'd4, 32'h0000006F, 32'h000FF7FE);
    send("j_fmt", 3'd4, 32'h0000006F, 32'h000FF7FE, 1'b1, 32);
    receive(2, 1'b0);
    push_model("j_ovf", 3'd4, 32'hABCDE06F, 32'h00100801);
    send("j_ovf", 3'd4, 32'hABCDE06F, 32'h00100801, 1'b0, 32);
    receive(0, 1'b0);
    push_model("u_ovf", 3'd3, 32'h00000037, 32'h12345001);
    send("u_ovf", 3'd3, 32'h00000037, 32'h12345001, 1'b0, 32);
    receive(0, 1'b0);
    push("rsv_fmt", 32'hDEADBEEF, 1'b0, 1'b0);
    send("rsv_fmt", 3'd6, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32);
    receive(0, 1'b0);

    // Reset after 10 enabled bits discards the word.
    send("rst_mid", 3'd0, 32'h00000013, 32'hFFFFFFFF, 1'b0, 10);
    rst_n = 1'b0;
    #1;
    check("rstmid_insn",  bus.o_insn, 32'd0);
    check("rstmid_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rstmid_busy",  {31'd0, busy}, 32'd0);
    check("rstmid_flags", {30'd0, bus.o_ovf, bus.o_misalign}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    push("u_fmt", 32'h12345037, 1'b0, 1'b0);
    send("u_fmt", 3'd3, 32'h00000037, 32'h12345000, 1'b0, 32);
    receive(0, 1'b0);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
